vga_screen_select: RTL

VGA_SCREEN_SELECT -- requirements
Module: vga_screen_select

---
 rtl/vga_screen_select.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/vga_screen_select.sv
// vga_screen_select: picks one of NUM_SCREENS VGA sources and drives it to the
// shared outputs. A new screen only takes over on a frame boundary, which is
// the falling edge of the current screen's vsync.
// Optional feature macro: SCREEN_FADE_EN. When defined, each switch blanks
// the colors for BLANK_FRAMES frames of the new screen.
module vga_screen_select #(
  parameter int NUM_SCREENS    = 8,
  parameter int SEL_W          = 3,
  parameter int COLOR_W        = 4,
  parameter int DEFAULT_SCREEN = 1,
  parameter int BLANK_FRAMES   = 2
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [SEL_W-1:0]                   sel,
  input  logic [NUM_SCREENS-1:0]             hsync_in,
  input  logic [NUM_SCREENS-1:0]             vsync_in,
  input  logic [NUM_SCREENS*3*COLOR_W-1:0]   rgb_in,
  output logic                               hSync,
  output logic                               vSync,
  output logic [COLOR_W-1:0]                 VGA_R,
  output logic [COLOR_W-1:0]                 VGA_G,
  output logic [COLOR_W-1:0]                 VGA_B,
  output logic [SEL_W-1:0]                   active,
  output logic                               switching
);

  localparam int PIX_W = 3 * COLOR_W;

`ifdef SCREEN_FADE_EN
  typedef enum logic [1:0] {ACTIVE, PENDING, BLANK} state_t;
  logic [3:0] cnt, cnt_d;
`else
  typedef enum logic [1:0] {ACTIVE, PENDING} state_t;
`endif

  state_t           state, state_d;
  logic [SEL_W-1:0] pending, pending_d, active_d;
  logic [SEL_W-1:0] sel_map;
  logic             vs_q;
  logic             frame_edge;
  logic [PIX_W-1:0] pix;

  // Out-of-range requests fall back to the default screen.
  assign sel_map    = (32'(sel) < 32'(NUM_SCREENS)) ? sel : SEL_W'(DEFAULT_SCREEN);
  assign frame_edge = vs_q & ~vsync_in[active];
  assign pix        = rgb_in[active*PIX_W +: PIX_W];
  assign switching  = (state != ACTIVE);

  // State and selection registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ACTIVE;
      active  <= SEL_W'(DEFAULT_SCREEN);
      pending <= SEL_W'(DEFAULT_SCREEN);
      vs_q    <= 1'b1;
`ifdef SCREEN_FADE_EN
      cnt     <= 4'd0;
`endif
    end else begin
      state   <= state_d;
      active  <= active_d;
      pending <= pending_d;
      vs_q    <= vsync_in[active];
`ifdef SCREEN_FADE_EN
      cnt     <= cnt_d;
`endif
    end
  end

  // Next-state: requests wait in PENDING until the current screen's frame ends.
  always_comb begin
    state_d   = state;
    active_d  = active;
    pending_d = pending;
`ifdef SCREEN_FADE_EN
    cnt_d     = cnt;
`endif
    case (state)
      ACTIVE: begin
        if (sel_map != active) begin
          pending_d = sel_map;
          state_d   = PENDING;
        end
      end
      PENDING: begin
        if (frame_edge) begin
          // Commit what was latched; a sel change this same cycle is picked
          // up afterwards as a fresh request.
          active_d = pending;
`ifdef SCREEN_FADE_EN
          state_d  = BLANK;
          cnt_d    = 4'(BLANK_FRAMES);
`else
          state_d  = ACTIVE;
`endif
        end else if (sel_map == active) begin
          state_d = ACTIVE;
        end else begin
          pending_d = sel_map;
        end
      end
`ifdef SCREEN_FADE_EN
      BLANK: begin
        if (sel_map != active) pending_d = sel_map;
        if (frame_edge) begin
          cnt_d = cnt - 4'd1;
          if (cnt <= 4'd1) state_d = (sel_map != active) ? PENDING : ACTIVE;
        end
      end
`endif
      default: state_d = ACTIVE;
    endcase
  end

  // Registered video outputs, one cycle behind the selected screen.
  always_ff @(posedge clk) begin
    if (reset) begin
      hSync <= 1'b1;
      vSync <= 1'b1;
      VGA_R <= '0;
      VGA_G <= '0;
      VGA_B <= '0;
    end else begin
      hSync <= hsync_in[active];
      vSync <= vsync_in[active];
      VGA_R <= pix[PIX_W-1 -: COLOR_W];
      VGA_G <= pix[2*COLOR_W-1 -: COLOR_W];
      VGA_B <= pix[COLOR_W-1:0];
`ifdef SCREEN_FADE_EN
      if (state == BLANK) begin
        VGA_R <= '0;
        VGA_G <= '0;
        VGA_B <= '0;
      end
`endif
    end
  end

endmodule
